// File: rtl/i2s_mic_pair_ctrl.sv
// rtl/i2s_mic_pair_ctrl.sv - I2S master and capture scheduler for one stereo mic pair
module i2s_mic_pair_ctrl #(
  parameter int WIDTH          = 16,
  parameter int SLOT           = 32,
  parameter int CLK_DIV        = 4,
  parameter int STARTUP_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             sck,
  output logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] sample_left,
  output logic [WIDTH-1:0] sample_right,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overflow,
  output logic             active
);

  localparam int DW  = $clog2(CLK_DIV);
  localparam int BW  = $clog2(2*SLOT);
  localparam int WCW = $clog2(STARTUP_FRAMES + 2);

  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0]  DIV_PRE   = DW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(2*SLOT - 1);
  localparam logic [BW-1:0]  BIT_SLOT  = BW'(SLOT);
  localparam logic [WCW-1:0] WARM_INIT = WCW'(STARTUP_FRAMES);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, STOP} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div, div_nxt;
  logic [BW-1:0]     bitcnt, bit_nxt;
  logic [WCW-1:0]    warm_cnt;
  logic              stop_push;
  logic              frame_done, rise, push, warm_dec, idle_exit;
  logic              in_right;
  logic [BW-1:0]     pos;
  logic [WIDTH-1:0]  left_asm, right_asm;

  logic [2*WIDTH-1:0] mem [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count;
  logic               pop, accept;

  assign active     = (state != IDLE);
  assign frame_done = active && (div == DIV_LAST) && (bitcnt == BIT_LAST);
  assign rise       = active && (div == DIV_PRE);
  assign in_right   = (bitcnt >= BIT_SLOT);
  assign pos        = in_right ? (bitcnt - BIT_SLOT) : bitcnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A frame finishing on the same edge enable drops goes straight to IDLE
  // rather than starting a fresh frame in STOP.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    warm_dec  = 1'b0;
    idle_exit = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          idle_exit = 1'b1;
          state_nxt = (STARTUP_FRAMES > 0) ? WARMUP : RUN;
        end
      end
      WARMUP: begin
        if (frame_done) begin
          warm_dec = 1'b1;
          if (!enable)                    state_nxt = IDLE;
          else if (warm_cnt == WCW'(1))   state_nxt = RUN;
        end else if (!enable) begin
          state_nxt = STOP;
        end
      end
      RUN: begin
        if (frame_done) begin
          push = 1'b1;
          if (!enable) state_nxt = IDLE;
        end else if (!enable) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (frame_done) begin
          push      = stop_push;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    div_nxt = div;
    bit_nxt = bitcnt;
    if (!active) begin
      div_nxt = '0;
      bit_nxt = '0;
    end else if (div == DIV_LAST) begin
      div_nxt = '0;
      bit_nxt = (bitcnt == BIT_LAST) ? '0 : bitcnt + BW'(1);
    end else begin
      div_nxt = div + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      bitcnt    <= '0;
      sck       <= 1'b0;
      ws        <= 1'b0;
      warm_cnt  <= '0;
      stop_push <= 1'b0;
    end else begin
      div    <= div_nxt;
      bitcnt <= bit_nxt;
      sck    <= (div_nxt >= DIV_HALF);
      ws     <= (bit_nxt >= BIT_SLOT);
      if (idle_exit)     warm_cnt <= WARM_INIT;
      else if (warm_dec) warm_cnt <= warm_cnt - WCW'(1);
      // remembers whether STOP was entered from RUN
      if (state != STOP) stop_push <= (state == RUN);
    end
  end

  // One-bit I2S delay: slot position p carries channel bit WIDTH-p.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_asm  <= '0;
      right_asm <= '0;
    end else begin
      if (active && div == '0 && bitcnt == '0)     left_asm  <= '0;
      if (active && div == '0 && bitcnt == BIT_SLOT) right_asm <= '0;
      if (rise) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (pos == BW'(WIDTH - i)) begin
            if (in_right) right_asm[i] <= sd;
            else          left_asm[i]  <= sd;
          end
        end
      end
    end
  end

  assign sample_valid = (count != 2'd0);
  assign pop          = sample_valid && sample_ready;
  assign accept       = push && ((count != 2'd2) || pop);
  assign sample_left  = mem[rd_ptr][2*WIDTH-1:WIDTH];
  assign sample_right = mem[rd_ptr][WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {left_asm, right_asm};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, accept} - {1'b0, pop};
      if (idle_exit)            overflow <= 1'b0;
      else if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_mic_pair_ctrl.sv
// tb/tb_i2s_mic_pair_ctrl.sv - directed vector bench for i2s_mic_pair_ctrl
module tb_i2s_mic_pair_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sd = 1'b0;
  logic        sample_ready = 1'b0;
  logic        sck, ws, sample_valid, overflow, active;
  logic [15:0] sample_left, sample_right;

  logic        en0 = 1'b0;
  logic        rdy0 = 1'b0;
  logic        sd0 = 1'b1;
  logic        sck0, ws0, valid0, ovf0, act0;
  logic [15:0] left0, right0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mic_l = 16'hA5C3;
  logic [15:0] mic_r = 16'h1234;

  always #5 clk = ~clk;

  i2s_mic_pair_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .sck(sck), .ws(ws), .sd(sd),
    .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overflow(overflow), .active(active)
  );

  i2s_mic_pair_ctrl #(.STARTUP_FRAMES(0)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .sck(sck0), .ws(ws0), .sd(sd0),
    .sample_left(left0), .sample_right(right0),
    .sample_valid(valid0), .sample_ready(rdy0),
    .overflow(ovf0), .active(act0)
  );

  // Mic pair model: tracks slot position from sck falls and ws edges only.
  int          mp = 0;
  logic        psck = 1'b0, pws = 1'b0;
  logic [15:0] word;
  always @(negedge clk) begin
    if (active !== 1'b1)      mp = 0;
    else if (psck && !sck)    mp = (ws != pws) ? 0 : mp + 1;
    psck = sck;
    pws  = ws;
    word = ws ? mic_r : mic_l;
    sd   = (mp >= 1 && mp <= 16) ? word[16-mp] : 1'b0;
  end

  typedef struct packed {
    logic [15:0] wait_n;
    logic        rst, en, rdy;
    logic [15:0] ml, mr;
    logic        sck, ws, act, vld, dchk;
    logic [15:0] l, r;
    logic        ovf;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    //                wait rst en rdy  ml        mr        sck ws act vld dchk l         r         ovf
    vecs[0]  = '{16'd3,   1, 0, 0, 16'hA5C3, 16'h1234, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0};
    vecs[1]  = '{16'd1,   0, 1, 0, 16'hA5C3, 16'h1234, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[2]  = '{16'd2,   0, 1, 0, 16'hA5C3, 16'h1234, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[3]  = '{16'd1,   0, 1, 0, 16'hA5C3, 16'h1234, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[4]  = '{16'd1,   0, 1, 0, 16'hA5C3, 16'h1234, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[5]  = '{16'd124, 0, 1, 0, 16'hA5C3, 16'h1234, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[6]  = '{16'd2,   0, 1, 0, 16'hA5C3, 16'h1234, 1, 1, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[7]  = '{16'd126, 0, 1, 0, 16'hA5C3, 16'h1234, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[8]  = '{16'd511, 0, 1, 0, 16'hA5C3, 16'h1234, 1, 1, 1, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[9]  = '{16'd1,   0, 1, 0, 16'hA5C3, 16'h1234, 0, 0, 1, 1, 1, 16'hA5C3, 16'h1234, 0};
    vecs[10] = '{16'd256, 0, 1, 0, 16'h0F0F, 16'h5678, 0, 0, 1, 1, 1, 16'hA5C3, 16'h1234, 0};
    vecs[11] = '{16'd256, 0, 1, 0, 16'hFFFF, 16'h0000, 0, 0, 1, 1, 1, 16'hA5C3, 16'h1234, 1};
    vecs[12] = '{16'd1,   0, 1, 1, 16'h1357, 16'h2468, 0, 0, 1, 1, 1, 16'h0F0F, 16'h5678, 1};
    vecs[13] = '{16'd1,   0, 1, 1, 16'h1357, 16'h2468, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 1};
    vecs[14] = '{16'd254, 0, 1, 1, 16'h1357, 16'h2468, 0, 0, 1, 1, 1, 16'h1357, 16'h2468, 1};
    vecs[15] = '{16'd1,   0, 1, 1, 16'h1357, 16'h2468, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1};

    #1;
    for (int i = 0; i < 16; i++) begin
      rst          = vecs[i].rst;
      enable       = vecs[i].en;
      sample_ready = vecs[i].rdy;
      mic_l        = vecs[i].ml;
      mic_r        = vecs[i].mr;
      step(int'(vecs[i].wait_n));
      chk($sformatf("v%0d_sck", i), 32'(sck), 32'(vecs[i].sck));
      chk($sformatf("v%0d_ws", i), 32'(ws), 32'(vecs[i].ws));
      chk($sformatf("v%0d_active", i), 32'(active), 32'(vecs[i].act));
      chk($sformatf("v%0d_valid", i), 32'(sample_valid), 32'(vecs[i].vld));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      if (vecs[i].dchk) begin
        chk($sformatf("v%0d_left", i), 32'(sample_left), 32'(vecs[i].l));
        chk($sformatf("v%0d_right", i), 32'(sample_right), 32'(vecs[i].r));
      end
    end

    // enable dropped mid-frame in RUN: frame completes and is delivered
    mic_l = 16'hBEEF; mic_r = 16'hCAFE; sample_ready = 1'b0;
    step(63);
    enable = 1'b0;
    step(191);
    chk("stop_run_active_before_end", 32'(active), 32'd1);
    chk("stop_run_valid_before_end", 32'(sample_valid), 32'd0);
    step(1);
    chk("stop_run_idle_active", 32'(active), 32'd0);
    chk("stop_run_idle_sck", 32'(sck), 32'd0);
    chk("stop_run_idle_ws", 32'(ws), 32'd0);
    chk("stop_run_valid", 32'(sample_valid), 32'd1);
    chk("stop_run_left", 32'(sample_left), 32'hBEEF);
    chk("stop_run_right", 32'(sample_right), 32'hCAFE);
    chk("stop_run_ovf_kept", 32'(overflow), 32'd1);
    enable = 1'b1;
    step(1);
    chk("reenable_ovf_cleared", 32'(overflow), 32'd0);
    chk("reenable_active", 32'(active), 32'd1);
    sample_ready = 1'b1;
    step(1);
    chk("reenable_pop", 32'(sample_valid), 32'd0);

    // enable dropped during WARMUP: nothing delivered
    step(99);
    enable = 1'b0; sample_ready = 1'b0;
    step(155);
    chk("stop_warm_active_before_end", 32'(active), 32'd1);
    step(1);
    chk("stop_warm_idle_active", 32'(active), 32'd0);
    chk("stop_warm_no_data", 32'(sample_valid), 32'd0);

    // full buffer with push and pop on the same edge
    enable = 1'b1;
    step(1);
    step(768);
    chk("full_first_valid", 32'(sample_valid), 32'd1);
    chk("full_first_left", 32'(sample_left), 32'hBEEF);
    mic_l = 16'h1111; mic_r = 16'h2222;
    step(256);
    chk("full_head_kept", 32'(sample_left), 32'hBEEF);
    mic_l = 16'h3333; mic_r = 16'h4444;
    step(255);
    sample_ready = 1'b1;
    step(1);
    chk("pushpop_valid", 32'(sample_valid), 32'd1);
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    chk("pushpop_left", 32'(sample_left), 32'h1111);
    chk("pushpop_right", 32'(sample_right), 32'h2222);
    step(1);
    chk("pushpop_second_valid", 32'(sample_valid), 32'd1);
    chk("pushpop_second_left", 32'(sample_left), 32'h3333);
    chk("pushpop_second_right", 32'(sample_right), 32'h4444);
    step(1);
    chk("pushpop_drained", 32'(sample_valid), 32'd0);
    chk("pushpop_ovf_after", 32'(overflow), 32'd0);
    sample_ready = 1'b0;

    // reset mid-frame with one entry buffered
    step(254);
    chk("rst_pre_valid", 32'(sample_valid), 32'd1);
    step(64);
    rst = 1'b1;
    step(1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_ws", 32'(ws), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_left", 32'(sample_left), 32'd0);
    chk("rst_right", 32'(sample_right), 32'd0);
    rst = 1'b0;
    step(1);
    chk("rst_restart_active", 32'(active), 32'd1);
    chk("rst_restart_sck", 32'(sck), 32'd0);
    chk("rst_restart_ws", 32'(ws), 32'd0);
    step(2);
    chk("rst_restart_sck_high", 32'(sck), 32'd1);
    step(765);
    chk("rst_warm_no_early_valid", 32'(sample_valid), 32'd0);
    step(1);
    chk("rst_warm_valid", 32'(sample_valid), 32'd1);
    chk("rst_warm_left", 32'(sample_left), 32'h3333);
    chk("rst_warm_right", 32'(sample_right), 32'h4444);

    // no warm-up, sd stuck high
    en0 = 1'b1;
    step(1);
    chk("nowarm_active", 32'(act0), 32'd1);
    step(255);
    chk("nowarm_no_early_valid", 32'(valid0), 32'd0);
    step(1);
    chk("nowarm_valid", 32'(valid0), 32'd1);
    chk("nowarm_left", 32'(left0), 32'hFFFF);
    chk("nowarm_right", 32'(right0), 32'hFFFF);
    chk("nowarm_ovf", 32'(ovf0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_mic_pair_ctrl.md
Name: i2s_mic_pair_ctrl

Overview:
- I2S bus master and capture scheduler for one two-microphone pair.
- Generates sck and ws from the system clock and runs a mic warm-up period.
- Samples the shared sd line and assembles left/right words per frame.
- Delivers each stereo pair through a 2-entry buffered valid/ready stream toward the beamforming datapath.

Parameters:
- WIDTH, 16: captured bits per channel (MSB first); slot bits beyond WIDTH are ignored.
- SLOT, 32: sck periods per channel slot; one frame = 2*SLOT sck periods. Legal range is SLOT >= WIDTH+1.
- CLK_DIV, 4: clk cycles per sck period. Must be even and >= 2.
- STARTUP_FRAMES, 2: complete frames discarded after enable, for mic settling. 0 means no discard.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level: capture requested.
- sck  out  1  I2S bit clock (registered).
- ws  out  1  I2S word select (registered); 0 = left slot, 1 = right slot.
- sd  in  1  serial data from both mics, already synchronised to clk.
- sample_left  out  WIDTH  left word of the head buffer entry.
- sample_right  out  WIDTH  right word of the head buffer entry.
- sample_valid  out  1  head entry present.
- sample_ready  in  1  consumer accepts the head entry.
- overflow  out  1  sticky: a completed pair was dropped because the buffer was full.
- active  out  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - sck=0, ws=0, sample_valid=0, overflow=0, active=0.
  - sample_left and sample_right = 0.
  - Buffer emptied; state IDLE; divider, bit and warm-up counters cleared.
- Reset has priority over every other event and aborts any frame mid-flight, with no partial output.
- States:
  - IDLE: sck=0, ws=0 held; divider and bit counters held at 0.
    - enable=1 -> WARMUP if STARTUP_FRAMES>0, else RUN.
    - Overflow is cleared on this transition.
  - WARMUP: bus runs normally. Each completed frame decrements the warm-up count; no data is pushed.
    - When the count reaches 0 -> RUN.
    - enable=0 -> STOP.
  - RUN: each completed frame pushes {left,right}.
    - enable=0 -> STOP.
  - STOP: finish the current frame, pushing it only if STOP was entered from RUN, then -> IDLE.
    - enable changes during STOP are ignored; IDLE re-samples enable on the following cycle.
- Bus timing:
  - div counts 0..CLK_DIV-1 per sck period; sck = (div >= CLK_DIV/2).
  - bit counts 0..2*SLOT-1 and advances when div wraps.
  - ws = (bit >= SLOT); ws therefore changes only coincident with sck falling.
  - First active cycle after leaving IDLE: div=0, bit=0.
- Capture (I2S one-bit delay):
  - sd is sampled in the clk cycle where sck rises (div transitions CLK_DIV/2-1 -> CLK_DIV/2).
  - Slot position p = bit mod SLOT. Positions p=1..WIDTH load channel bit WIDTH-p, so MSB first.
  - Position 0 and positions > WIDTH are ignored.
  - The left assembly register is cleared at the start of bit 0; the right at the start of bit SLOT.
- Frame completion: the clk cycle with bit=2*SLOT-1 and div=CLK_DIV-1. The push (or warm-up decrement) happens on that edge.
- Buffer:
  - 2 entries, FIFO order.
  - sample_valid rises the cycle after the push edge (push-to-valid latency 1).
  - Head data stays stable while sample_valid=1 and sample_ready=0.
  - Pop on sample_valid & sample_ready.
  - Simultaneous push and pop with 2 entries is accepted: no overflow, count unchanged.
  - Push while full with no pop: new pair dropped, overflow set. Overflow clears only on rst or the IDLE exit.
- Frame period = 2*SLOT*CLK_DIV clk cycles (256 at defaults).

Test Plan:
- Defaults, enable held high from cycle 0, mic model drives left=0xA5C3 and right=0x1234:
  - sck period = 4 clk; ws toggles every 128 clk.
  - First sample_valid appears 3*256 clk after entering WARMUP, carrying 0xA5C3 / 0x1234.
  - Every later pair arrives each 256 clk.
- sample_ready=0 across 3 RUN frames:
  - First two pairs are retained in order.
  - Third pair is dropped and overflow=1.
  - Then ready=1 pops both pairs with overflow staying 1.
  - An enable 0->1 cycle through IDLE clears overflow.
- sample_ready=1 continuous, full buffer with push and pop in the same cycle: no overflow, sample_valid stays 1.
- enable dropped mid-frame in RUN:
  - That frame completes and is delivered.
  - Then IDLE with sck=0, ws=0, active=0.
  - The same drop during WARMUP delivers nothing.
- rst pulsed mid-frame with 1 entry buffered: next cycle all outputs are at reset values and the buffer is empty. Re-enable restarts warm-up from bit 0.
- STARTUP_FRAMES=0, sd stuck at 1: first pair is 0xFFFF / 0xFFFF, with sample_valid at 256 clk after RUN entry.
